uart_rx: RTL and testbench

Serial receiver for the core's `RXD` line; the counterpart of the CPU's `TXD` transmitter. It deserialises 8N1 frames (one start bit, 8 data bits LSB first, one stop bit, no parity), buffers received bytes in a small FIFO, and presents them to the CPU's I/O logic through a show-ahead pop interface with sticky error flags. It sits between the board RX pin and the CPU's `RXD`/peripheral read path, in the same clock domain as the CPU.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding a small show-ahead receive FIFO.
// The rxd pin is double-flopped into rxs. A down-counting baud timer places a
// sample point in the middle of each bit. Good bytes are pushed into the FIFO.
// Framing and overrun problems raise sticky flags until clr_err is asserted.
//
// Pop handshake: rx_valid acts as "valid" and rd_en acts as "ready". A byte
// leaves the FIFO on a rising edge only when rx_valid and rd_en are both 1.
// While rx_valid is 1, rx_data always shows the head entry.
module uart_rx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic [2:0] dbg_state
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

  logic rxs, baud_tick, push_req, frame_set;
  logic fifo_empty, fifo_full, pop, push_ok;

  assign rxs       = sync2_q;
  assign baud_tick = (baud_q == '0);

  // Two-stage synchronizer. It resets to the idle-high line level.
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
  end

  // Frame FSM: start detection, mid-bit sampling, stop check and break wait.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          baud_d  = HALF_M1;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (!rxs) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
            baud_d  = DIV_M1;
          end else begin
            // The line went high again: this was a glitch, not a start bit.
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          baud_d  = DIV_M1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (rxs) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping and sticky error flags. When an error is set and cleared
  // in the same cycle, the set wins.
  always_comb begin
    fifo_empty = (wr_q == rd_q);
    fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop        = rd_en && !fifo_empty;
    // When the FIFO is full, a pop in the same cycle frees the slot for the push.
    push_ok    = push_req && (!fifo_full || pop);
    mem_d      = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = shift_q;
    wr_d       = wr_q + {{AW{1'b0}}, push_ok};
    rd_d       = rd_q + {{AW{1'b0}}, pop};
    overrun_d  = overrun_q;
    frame_err_d = frame_err_q;
    if (clr_err) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (push_req && fifo_full && !pop) overrun_d = 1'b1;
    if (frame_set) frame_err_d = 1'b1;
  end

  // State register for the synchronizer, the FSM, the FIFO and the flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rx_data   = mem_q[rd_q[AW-1:0]];
  assign rx_valid  = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLK_DIV=16 and FIFO_DEPTH=4.
// The clock period is 10 ns, so one bit lasts 160 ns at the exact baud rate.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic       clk, resetn, rxd, rd_en, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  typedef struct {
    logic [7:0] data;
    int         bit_ns;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs [6];

  uart_rx #(.CLK_DIV(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive one 8N1 frame. The line is left at the stop-bit level when the task returns.
  task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_bit,
                            input bit do_align);
    if (do_align) begin
      @(posedge clk);
      #2;
    end
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_bit;
    #(bit_ns);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({name, "_data"}, {24'd0, rx_data}, {24'd0, exp});
    rd_en = 1'b1;
    @(posedge clk);
    #2;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(posedge clk);
    #2;
    clr_err = 1'b0;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, bit_ns: 160, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, bit_ns: 155, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, bit_ns: 155, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h00, bit_ns: 165, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'hFF, bit_ns: 165, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h3C, bit_ns: 160, exp_data: 8'h3C, exp_ferr: 1'b0};

    rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0; resetn = 1'b1;
    #3 resetn = 1'b0;
    #1;
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    wait_cycles(3);
    resetn = 1'b1;
    wait_cycles(3);

    // Single frame at the exact rate: rx_valid rises 155 edges after the pin falls.
    lat = 0;
    fork
      send_frame(8'hA5, 160, 1'b1, 1'b1);
      begin
        @(posedge clk);
        for (int k = 1; k <= 400 && lat == 0; k++) begin
          @(posedge clk);
          #1;
          if (rx_valid) lat = k;
        end
      end
    join
    wait_cycles(2);
    check("latency", lat, 32'd155);
    pop_check("single", 8'hA5);
    check("single_empty", {31'd0, rx_valid}, 32'd0);

    // Frames from the vector table, including the ±3% baud cases.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].bit_ns, 1'b1, 1'b1);
      wait_cycles(4);
      check($sformatf("vec%0d_ferr", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_ferr});
      pop_check($sformatf("vec%0d", v), vecs[v].exp_data);
      check($sformatf("vec%0d_empty", v), {31'd0, rx_valid}, 32'd0);
    end

    // Five back-to-back frames with no pops: the fifth is dropped.
    send_frame(8'h01, 160, 1'b1, 1'b1);
    for (int b = 2; b <= 5; b++) send_frame(8'(b), 160, 1'b1, 1'b0);
    wait_cycles(4);
    check("b2b_overrun", {31'd0, overrun}, 32'd1);
    for (int b = 1; b <= 4; b++) pop_check($sformatf("b2b_%0d", b), 8'(b));
    check("b2b_empty", {31'd0, rx_valid}, 32'd0);
    pulse_clr();
    check("b2b_clr", {31'd0, overrun}, 32'd0);

    // FIFO full, with a pop in the same cycle as the fifth push.
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 160, 1'b1, 1'b1);
      wait_cycles(2);
    end
    fork
      send_frame(8'h55, 160, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #2 rd_en = 1'b1;
        @(posedge clk);
        #2 rd_en = 1'b0;
      end
    join
    wait_cycles(4);
    check("fullpop_overrun", {31'd0, overrun}, 32'd0);
    pop_check("fullpop_2", 8'h02);
    pop_check("fullpop_3", 8'h03);
    pop_check("fullpop_4", 8'h04);
    pop_check("fullpop_55", 8'h55);
    check("fullpop_empty", {31'd0, rx_valid}, 32'd0);

    // Low stop bit followed by a line held low for 30 bit times.
    send_frame(8'h3C, 160, 1'b0, 1'b1);
    #(30 * 160);
    check("ferr_flag", {31'd0, frame_err}, 32'd1);
    check("ferr_wait_state", {29'd0, dbg_state}, {29'd0, ST_WAIT_IDLE});
    rxd = 1'b1;
    wait_cycles(40);
    check("ferr_idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("ferr_not_stored", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h7E, 160, 1'b1, 1'b1);
    wait_cycles(4);
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);
    pop_check("ferr_7e", 8'h7E);
    check("ferr_7e_empty", {31'd0, rx_valid}, 32'd0);
    pulse_clr();
    check("ferr_clr", {31'd0, frame_err}, 32'd0);

    // A 6-cycle low glitch on an idle line is rejected.
    @(posedge clk);
    #2 rxd = 1'b0;
    #60 rxd = 1'b1;
    wait_cycles(30);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_ferr", {31'd0, frame_err}, 32'd0);
    check("glitch_overrun", {31'd0, overrun}, 32'd0);
    check("glitch_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Reset in the middle of data bit 4, with a byte already buffered.
    send_frame(8'h11, 160, 1'b1, 1'b1);
    wait_cycles(4);
    check("prerst_valid", {31'd0, rx_valid}, 32'd1);
    fork
      send_frame(8'hAA, 160, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (88) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
      end
    join
    wait_cycles(300);
    for (int d = 0; d < 8 && rx_valid; d++) begin
      rd_en = 1'b1;
      @(posedge clk);
      #2 rd_en = 1'b0;
    end
    pulse_clr();
    send_frame(8'h81, 160, 1'b1, 1'b1);
    wait_cycles(4);
    check("postrst_ferr", {31'd0, frame_err}, 32'd0);
    pop_check("postrst_81", 8'h81);
    check("postrst_empty", {31'd0, rx_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
